// File: rtl/deser8_if.sv
// Serial-in / byte-out bundle for deser8: bit stream in, byte handshake out.
interface deser8_if;
  logic       din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [2:0] bit_idx;
  logic       overrun;

  modport slave (
    input  din, din_valid, dout_ready,
    output dout, dout_valid, bit_idx, overrun
  );

  modport master (
    output din, din_valid, dout_ready,
    input  dout, dout_valid, bit_idx, overrun
  );
endinterface

// File: rtl/deser8.sv
// 1:8 deserializer: 3-bit slot counter, demux into an assembly register, 1-entry output hold.
// Define DESER8_MSB_FIRST_EN to place the first received bit in dout[7] instead of dout[0].
module deser8 (
  input  logic     clk,
  input  logic     rst_n,
  deser8_if.slave  bus
);
  typedef enum logic {EMPTY, FULL} hold_t;

  hold_t      st;
  logic [2:0] idx;
  logic [2:0] slot;
  logic [7:0] asm_q;
  logic [7:0] asm_nxt;
  logic       done;

`ifdef DESER8_MSB_FIRST_EN
  assign slot = 3'd7 - idx;
`else
  assign slot = idx;
`endif

  // Next assembly value includes the bit landing this edge, so a completing byte loads whole.
  always_comb begin
    asm_nxt = asm_q;
    if (bus.din_valid) asm_nxt[slot] = bus.din;
  end

  assign done           = bus.din_valid && (idx == 3'd7);
  assign bus.bit_idx    = idx;
  assign bus.dout_valid = (st == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= EMPTY;
      idx         <= 3'd0;
      asm_q       <= 8'h00;
      bus.dout    <= 8'h00;
      bus.overrun <= 1'b0;
    end else begin
      bus.overrun <= 1'b0;
      if (bus.din_valid) begin
        asm_q <= asm_nxt;
        idx   <= idx + 3'd1;
      end
      case (st)
        EMPTY: if (done) begin
          bus.dout <= asm_nxt;
          st       <= FULL;
        end
        FULL: begin
          if (done && bus.dout_ready) bus.dout <= asm_nxt;
          else if (done)              bus.overrun <= 1'b1;
          else if (bus.dout_ready)    st <= EMPTY;
        end
        default: st <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_deser8.sv
// Bench for deser8: fixed vector table, directed corner sequences, randomized run vs stream model.
module tb_deser8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  deser8_if bus();

  deser8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

`ifdef DESER8_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  localparam logic [7:0] B85 = MSB ? 8'hA1 : 8'h85;

  int checks = 0;
  int errors = 0;

  // Reference: count of accepted bits since reset, byte image, one-deep holding slot.
  int         m_cnt;
  logic [7:0] m_asm, m_dout;
  bit         m_full, m_ovr;

  task automatic check(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic sbit(input logic [7:0] b, input int k);
    return MSB ? b[7-k] : b[k];
  endfunction

  task automatic step(input logic r, input logic d, input logic dv, input logic rdy);
    rst_n = r; bus.din = d; bus.din_valid = dv; bus.dout_ready = rdy;
    @(posedge clk);
    if (!r) begin
      m_cnt = 0; m_asm = 8'h00; m_dout = 8'h00; m_full = 0; m_ovr = 0;
    end else begin
      m_ovr = 0;
      if (dv) begin
        m_asm[MSB ? 7 - (m_cnt % 8) : (m_cnt % 8)] = d;
        m_cnt++;
      end
      if (dv && (m_cnt % 8 == 0)) begin
        if (!m_full || rdy) begin m_dout = m_asm; m_full = 1; end
        else m_ovr = 1;
      end else if (m_full && rdy) m_full = 0;
    end
    #1;
    check("model_bit_idx", {5'b0, bus.bit_idx}, 8'(m_cnt % 8));
    check("model_dout", bus.dout, m_dout);
    check("model_dout_valid", {7'b0, bus.dout_valid}, {7'b0, m_full});
    check("model_overrun", {7'b0, bus.overrun}, {7'b0, m_ovr});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy_last, input bit gap);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, sbit(b, k), 1'b1, (k == 7) ? rdy_last : 1'b0);
      if (gap) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    end
  endtask

  typedef struct {
    logic r, d, dv, rdy;
    logic [2:0] idx;
    logic [7:0] dout;
    logic v, o;
  } vec_t;

  vec_t tbl[12];
  int   nv, no;

  initial begin
    bus.din = 0; bus.din_valid = 0; bus.dout_ready = 0;
    // reset, bits 1,0,1,0,0,0,0,1, hold, consume, ready while empty
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, B85,   1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, B85,   1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd0, B85,   1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd0, B85,   1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].d, tbl[i].dv, tbl[i].rdy);
      check($sformatf("tbl%0d_bit_idx", i), {5'b0, bus.bit_idx}, {5'b0, tbl[i].idx});
      check($sformatf("tbl%0d_dout", i), bus.dout, tbl[i].dout);
      check($sformatf("tbl%0d_valid", i), {7'b0, bus.dout_valid}, {7'b0, tbl[i].v});
      check($sformatf("tbl%0d_overrun", i), {7'b0, bus.overrun}, {7'b0, tbl[i].o});
    end

    // same byte with a gap after every bit
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h85, 1'b0, 1'b1);
    check("gap_dout", bus.dout, 8'h85);
    check("gap_valid", {7'b0, bus.dout_valid}, 8'd1);

    // held byte, second completion without ready -> dropped
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h85, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    check("ovr_dout", bus.dout, 8'h85);
    check("ovr_pulse", {7'b0, bus.overrun}, 8'd1);
    check("ovr_valid", {7'b0, bus.dout_valid}, 8'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse_end", {7'b0, bus.overrun}, 8'd0);

    // completion coinciding with consume -> back-to-back load
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h85, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    check("b2b_dout", bus.dout, 8'h3C);
    check("b2b_valid", {7'b0, bus.dout_valid}, 8'd1);
    check("b2b_overrun", {7'b0, bus.overrun}, 8'd0);

    // reset mid-byte
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("midrst_idx", {5'b0, bus.bit_idx}, 8'd0);
    send_byte(8'h5A, 1'b0, 1'b0);
    check("midrst_dout", bus.dout, 8'h5A);

    // three bytes streamed with ready held high
    step(1'b0, 1'b0, 1'b0, 1'b1);
    nv = 0; no = 0;
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 8; k++) begin
        step(1'b1, sbit(8'h11 * 8'(b + 1), k), 1'b1, 1'b1);
        if (bus.dout_valid) nv++;
        if (bus.overrun) no++;
      end
    check("stream_last_dout", bus.dout, 8'h33);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    if (bus.dout_valid) nv++;
    check("stream_valid_cycles", 8'(nv), 8'd3);
    check("stream_overruns", 8'(no), 8'd0);

    // randomized run against the model
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
